uart_tx_arb: RTL and testbench

Round-robin arbiter that shares the single `uart_tx` transmitter between four byte-stream requesters, such as the APB-fed TX FIFO path and local status/debug sources. It grants one requester at a time for a packet or a bounded burst. It accepts bytes through a valid/ready handshake, issues one-cycle shoot pulses to `uart_tx`, and paces transfers on the transmitter busy flag. It sits between the requesters and `uart_tx` (`datain_i`/`shoot_i`/`uart_busy_o`) in the `pclk` domain.

---
 rtl/uart_tx_arb_if.sv | 27 ++
 rtl/uart_tx_arb.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_arb.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_if.sv
// Requester byte streams and uart_tx side signals of the shared-transmitter arbiter.
interface uart_tx_arb_if;
  localparam int unsigned N_REQ  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ID_W   = 2;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic                    tx_busy;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_shoot;
  logic                    owner_vld;
  logic [ID_W-1:0]         owner_id;
  logic                    abort_o;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_shoot, owner_vld, owner_id, abort_o
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_shoot, owner_vld, owner_id, abort_o
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx between four byte-stream requesters,
// granting per packet or bounded burst and pacing shoots on the busy flag.
module uart_tx_arb #(
  parameter int unsigned MAXBURST = 16,
  parameter int unsigned TIMEOUT  = 255
) (
  input logic          pclk,
  input logic          preset,
  uart_tx_arb_if.slave bus
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned IDW  = 2;
  localparam int unsigned CW   = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_GUARD,
    S_DRAIN
  } state_e;

  state_e         state_q,     state_d;
  logic [IDW-1:0] owner_id_q,  owner_id_d;
  logic           owner_vld_q, owner_vld_d;
  logic [IDW-1:0] rr_ptr_q,    rr_ptr_d;
  logic [CW-1:0]  burst_cnt_q, burst_cnt_d;
  logic [CW-1:0]  to_cnt_q,    to_cnt_d;
  logic           rel_q,       rel_d;
  logic [DW-1:0]  tx_data_q,   tx_data_d;
  logic           tx_shoot_q,  tx_shoot_d;
  logic           abort_q,     abort_d;

  logic [IDW-1:0]  winner_c;
  logic [IDW-1:0]  rr_idx_c;
  logic            rr_hit_c;
  logic            own_valid_c;
  logic            own_last_c;
  logic [DW-1:0]   own_data_c;
  logic [NREQ-1:0] req_ready_c;
  logic [CW-1:0]   burst_inc_c;
  logic [CW-1:0]   to_inc_c;

  // Round-robin search starting one past the last released owner.
  always_comb begin
    winner_c = rr_ptr_q;
    rr_idx_c = rr_ptr_q;
    rr_hit_c = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      rr_idx_c = rr_ptr_q + IDW'(k);
      if (!rr_hit_c && bus.req_valid[rr_idx_c]) begin
        winner_c = rr_idx_c;
        rr_hit_c = 1'b1;
      end
    end
  end

  always_comb begin
    own_valid_c = bus.req_valid[owner_id_q];
    own_last_c  = bus.req_last[owner_id_q];
    own_data_c  = bus.req_data[{owner_id_q, 3'b000} +: DW];
    burst_inc_c = burst_cnt_q + CW'(1);
    to_inc_c    = to_cnt_q + CW'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    owner_id_d  = owner_id_q;
    owner_vld_d = owner_vld_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    to_cnt_d    = to_cnt_q;
    rel_d       = rel_q;
    tx_data_d   = tx_data_q;
    tx_shoot_d  = 1'b0;
    abort_d     = 1'b0;
    req_ready_c = '0;

    case (state_q)
      S_IDLE: begin
        if ((|bus.req_valid) && !bus.tx_busy) begin
          owner_id_d  = winner_c;
          owner_vld_d = 1'b1;
          burst_cnt_d = '0;
          to_cnt_d    = '0;
          state_d     = S_LOAD;
        end
      end

      S_LOAD: begin
        req_ready_c[owner_id_q] = !bus.tx_busy;
        // A busy transmitter freezes both transfer and the idle timeout.
        if (!bus.tx_busy) begin
          if (own_valid_c) begin
            tx_data_d   = own_data_c;
            tx_shoot_d  = 1'b1;
            burst_cnt_d = burst_inc_c;
            rel_d       = own_last_c || (burst_inc_c == CW'(MAXBURST));
            to_cnt_d    = '0;
            state_d     = S_GUARD;
          end else if (to_inc_c == CW'(TIMEOUT)) begin
            abort_d     = 1'b1;
            rr_ptr_d    = owner_id_q;
            owner_vld_d = 1'b0;
            to_cnt_d    = '0;
            state_d     = S_IDLE;
          end else begin
            to_cnt_d = to_inc_c;
          end
        end
      end

      // Busy may rise only one cycle after the shoot; skip sampling it here.
      S_GUARD: state_d = S_DRAIN;

      S_DRAIN: begin
        if (!bus.tx_busy) begin
          if (rel_q) begin
            rr_ptr_d    = owner_id_q;
            owner_vld_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            to_cnt_d = '0;
            state_d  = S_LOAD;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= S_IDLE;
      owner_id_q  <= '0;
      owner_vld_q <= 1'b0;
      rr_ptr_q    <= IDW'(3);
      burst_cnt_q <= '0;
      to_cnt_q    <= '0;
      rel_q       <= 1'b0;
      tx_data_q   <= '0;
      tx_shoot_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_id_q  <= owner_id_d;
      owner_vld_q <= owner_vld_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      rel_q       <= rel_d;
      tx_data_q   <= tx_data_d;
      tx_shoot_q  <= tx_shoot_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_shoot  = tx_shoot_q;
  assign bus.owner_vld = owner_vld_q;
  assign bus.owner_id  = owner_id_q;
  assign bus.abort_o   = abort_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus random packet mixes scored
// against a packet-level arbitration model and a busy-holding transmitter model.
module tb_uart_tx_arb;

  localparam int unsigned MAXB = 4;
  localparam int unsigned TOUT = 8;

  logic pclk = 1'b0;
  logic preset;
  uart_tx_arb_if bus ();

  uart_tx_arb #(.MAXBURST(MAXB), .TIMEOUT(TOUT)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [8:0] rq [4][$];
  logic [8:0] cq [4][$];
  logic [9:0] expq [$];
  logic [1:0] exp_ptr;
  int exp_aborts, seen_aborts;
  int cyc;
  int busy_rem, busy_len, pend_len, last_len, last_shoot, low_cnt;
  bit busy_arm, busy_force, rand_busy, busy_seen, prev_abort;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < 4; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Packet-level model: each grant goes to the next non-empty queue after the
  // previous owner and lasts until a last byte, MAXB bytes, or an exhausted queue.
  task automatic build_expect();
    int own, cnt, idx;
    bit hit;
    logic [8:0] b;
    for (int i = 0; i < 4; i++) cq[i] = rq[i];
    forever begin
      hit = 1'b0;
      own = 0;
      for (int k = 1; k <= 4; k++) begin
        idx = (int'(exp_ptr) + k) % 4;
        if (!hit && cq[idx].size() > 0) begin
          own = idx;
          hit = 1'b1;
        end
      end
      if (!hit) break;
      cnt = 0;
      forever begin
        b = cq[own].pop_front();
        expq.push_back({2'(own), b[7:0]});
        cnt++;
        if (b[8] || cnt == int'(MAXB)) break;
        if (cq[own].size() == 0) begin
          exp_aborts++;
          break;
        end
      end
      exp_ptr = 2'(own);
    end
  endtask

  task automatic drive();
    logic [8:0] h;
    for (int i = 0; i < 4; i++) begin
      if (rq[i].size() > 0) begin
        h = rq[i][0];
        bus.req_valid[i]       = 1'b1;
        bus.req_data[8*i +: 8] = h[7:0];
        bus.req_last[i]        = h[8];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[8*i +: 8] = 8'h00;
        bus.req_last[i]        = 1'b0;
      end
    end
    bus.tx_busy = busy_force || (busy_rem > 0);
    if (bus.tx_busy) busy_seen = 1'b1;
    else if (busy_seen) low_cnt++;
  endtask

  task automatic monitor();
    logic [9:0] e;
    if (busy_rem > 0) busy_rem--;
    if (busy_arm) begin
      busy_rem = pend_len;
      busy_arm = 1'b0;
    end
    if (bus.tx_shoot === 1'b1) begin
      chk("shoot_vs_busy", bus.tx_busy, 0);
      if (last_shoot >= 0) chk("shoot_gap", (cyc - last_shoot) >= (last_len + 3), 1);
      e = 'x;
      if (expq.size() > 0) e = expq.pop_front();
      chk("shoot_id_data", {bus.owner_id, bus.tx_data}, e);
      pend_len   = rand_busy ? int'($urandom_range(1, 4)) : busy_len;
      last_len   = pend_len;
      last_shoot = cyc;
      busy_arm   = 1'b1;
      busy_seen  = 1'b0;
      low_cnt    = 0;
    end
    if (bus.abort_o === 1'b1) begin
      seen_aborts++;
      chk("abort_after_timeout", low_cnt, TOUT + 1);
      chk("abort_one_cycle", prev_abort, 0);
    end
    prev_abort = bus.abort_o;
  endtask

  task automatic tick();
    int xi;
    xi = -1;
    #1;
    for (int i = 0; i < 4; i++) if (bus.req_valid[i] && bus.req_ready[i]) xi = i;
    @(posedge pclk);
    @(negedge pclk);
    cyc++;
    if (xi >= 0) void'(rq[xi].pop_front());
    monitor();
    drive();
  endtask

  task automatic run_done(input int budget);
    int n;
    n = 0;
    while (!(all_empty() && expq.size() == 0 && bus.owner_vld === 1'b0 &&
             busy_rem == 0 && !busy_arm) && n < budget) begin
      tick();
      n++;
    end
    chk("run_completes", n < budget, 1);
    chk("aborts_match", seen_aborts, exp_aborts);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_tx_data"},   bus.tx_data,   0);
    chk({tag, "_tx_shoot"},  bus.tx_shoot,  0);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_owner_vld"}, bus.owner_vld, 0);
    chk({tag, "_owner_id"},  bus.owner_id,  0);
    chk({tag, "_abort"},     bus.abort_o,   0);
  endtask

  initial begin
    int n, nb;
    bit lst;
    preset = 1'b1;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_busy = 1'b0;
    exp_ptr = 2'd3; exp_aborts = 0; seen_aborts = 0; cyc = 0;
    busy_rem = 0; busy_len = 3; pend_len = 3; last_len = 0; last_shoot = -1; low_cnt = 0;
    busy_arm = 1'b0; busy_force = 1'b0; rand_busy = 1'b0; busy_seen = 1'b0; prev_abort = 1'b0;

    repeat (2) @(negedge pclk);
    chk_zero_outputs("reset");
    preset = 1'b0;
    tick();

    // Single byte from requester 2: ready in cycle 1, shoot in cycle 2.
    rq[2].push_back(9'h15A);
    build_expect();
    drive();
    tick();
    chk("single_ready_c1", bus.req_ready, 4'b0100);
    chk("single_owner_vld", bus.owner_vld, 1);
    chk("single_owner_id", bus.owner_id, 2);
    tick();
    chk("single_shoot_c2", bus.tx_shoot, 1);
    chk("single_data_c2", bus.tx_data, 8'h5A);
    run_done(200);

    // Busy pacing with a long transmitter busy window.
    busy_len = 20;
    rq[3].push_back(9'h0A1);
    rq[3].push_back(9'h1A2);
    build_expect();
    drive();
    run_done(300);

    // Timeout: requester 0 stalls without last while requester 1 waits.
    busy_len = 3;
    rq[0].push_back(9'h011);
    rq[0].push_back(9'h022);
    rq[1].push_back(9'h133);
    build_expect();
    drive();
    run_done(300);

    // Busy high in IDLE must block every grant.
    busy_force = 1'b1;
    rq[0].push_back(9'h1C3);
    build_expect();
    drive();
    repeat (10) begin
      tick();
      chk("idle_busy_no_grant", {bus.owner_vld, bus.req_ready}, 0);
    end
    busy_force = 1'b0;
    drive();
    run_done(200);

    // Burst limit: 10-byte packet from requester 1 with requester 3 waiting.
    for (int j = 0; j < 10; j++) rq[1].push_back({(j == 9), 8'(j)});
    rq[3].push_back(9'h1EE);
    build_expect();
    drive();
    run_done(600);

    // Random packet mixes with random busy lengths.
    rand_busy = 1'b1;
    repeat (25) begin
      for (int i = 0; i < 4; i++) begin
        nb = int'($urandom_range(0, 5));
        for (int j = 0; j < nb; j++) begin
          lst = ($urandom_range(0, 3) == 0);
          if (j == nb - 1) lst = ($urandom_range(0, 4) != 0);
          rq[i].push_back({lst, 8'($urandom)});
        end
      end
      build_expect();
      drive();
      run_done(3000);
    end
    rand_busy = 1'b0;

    // Reset asserted while the owner is in DRAIN.
    busy_len = 6;
    for (int i = 0; i < 4; i++) begin
      rq[i].push_back({1'b0, 8'(8'h40 + i)});
      rq[i].push_back({1'b1, 8'(8'h50 + i)});
    end
    build_expect();
    drive();
    n = 0;
    while (bus.tx_shoot !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("rst_mid_reach_shoot", bus.tx_shoot, 1);
    tick();
    chk("rst_mid_owner_before", bus.owner_vld, 1);
    preset = 1'b1;
    #1;
    chk_zero_outputs("rst_mid");
    for (int i = 0; i < 4; i++) rq[i].delete();
    expq.delete();
    exp_ptr = 2'd3;
    drive();
    repeat (2) tick();
    preset = 1'b0;

    // Four-way tie after reset: requester 0 first, then strict rotation.
    rq[0].push_back(9'h180); rq[0].push_back(9'h181);
    rq[1].push_back(9'h190); rq[1].push_back(9'h191);
    rq[2].push_back(9'h1A0);
    rq[3].push_back(9'h1B0);
    build_expect();
    drive();
    run_done(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
